clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Consumes the divided clock produced by the prescaler and converts it into single-cycle enable pulses in the 100 MHz system domain, so the TD4 core runs on `clock_in` with a clock-enable instead of on a derived clock. Adds run/halt control and a debounced manual single-step button, with step pulses aligned to the slow clock's rising edge. Sits between the prescaler, the board switches/buttons and the CPU core's enable input.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth for every asynchronous input (minimum 2)
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable `clock_in` cycles before a button level is accepted (10 ms at 100 MHz; minimum 2)
- `COUNT_WIDTH`, 8, width of `tick_count`

- `clock_in`  in  1  system clock, 100 MHz
- `reset_n`  in  1  reset, asynchronous, active-low
- `slow_clock`  in  1  divided clock from the prescaler, treated as asynchronous
- `run_switch`  in  1  1 = free run, 0 = halt/step mode; asynchronous
- `step_button`  in  1  raw push button, active-high, bouncing
- `tick`  out  1  one-cycle CPU enable pulse
- `running`  out  1  high while FSM is in RUN
- `tick_count`  out  COUNT_WIDTH  number of ticks issued, wraps

## Operation
- `slow_clock`, `run_switch`, `step_button` each pass through SYNC_STAGES flops; all stages reset to 0.
- Edge detect: `rise` = synchronized slow_clock high and its previous-cycle value low; previous-value flop resets to 0.
- Debounce: counter clears whenever synchronized button equals debounced level; otherwise increments; at DEBOUNCE_CYCLES−1 the debounced level flips and counter clears. `press` = one-cycle pulse on debounced 0→1. Release generates nothing.
- FSM states HALT (reset), RUN, ARMED:
  - HALT: run=1 → RUN; else press → ARMED; else stay.
  - RUN: every `rise` produces a tick; run=0 → HALT.
  - ARMED: run=1 → RUN (pending step absorbed, no extra tick); else `rise` → tick, → HALT. Presses while ARMED ignored.
- Ticks issued only from RUN or ARMED on `rise`; at most one tick per slow_clock rising edge in any case.
- `tick_count` increments by 1 per tick, modulo 2^COUNT_WIDTH.
- `running` registered, high exactly while state is RUN.

## Timing
- All outputs registered. Reset values: `tick`=0, `running`=0, `tick_count`=0, state HALT, debounce counter 0, debounced level 0.
- `tick` asserts on the (SYNC_STAGES+1)th `clock_in` rising edge after the edge that first samples `slow_clock` high; width exactly one cycle.
- `tick_count` updates on the same edge `tick` asserts.
- `running` follows state: asserts 1 cycle after FSM enters RUN (SYNC_STAGES+1 cycles after switch sampled).
- Simultaneous run 1→0 and `rise` in RUN: tick issued (decision uses current state), then HALT.
- ARMED with `rise` and run=1 same cycle: tick issued, next state RUN.
- Button press of fewer than DEBOUNCE_CYCLES stable cycles: no press.
- `reset_n` low mid-operation: all state and outputs clear immediately (asynchronously); pending ARMED step discarded; a tick pulse in flight is cut.
- `slow_clock` held constant: no ticks in any state.

## Configuration
- `CLOCK_ENABLE_GEN_MANUAL_STEP_EN` defined: debounce logic and ARMED state present as above.
- Undefined: `step_button` ignored (port kept, unloaded), no debounce logic or step synchronizer, ARMED unreachable; HALT exits only to RUN. All other behaviour identical.

## Test plan
Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COUNT_WIDTH=4, slow_clock period 20 cycles.
- Reset, run_switch=1, 5 slow_clock periods -> 5 one-cycle ticks, each 3 cycles after slow_clock rises; tick_count=5; running=1.
- run_switch=1 for 17 periods -> tick_count wraps 15→0→1.
- run_switch=0, button high 10 cycles then release -> exactly one tick at next slow_clock rise; state back to HALT; tick_count+1.
- run_switch=0, button glitch 1,0,1,0 (3 cycles high max) -> no tick for 5 periods.
- ARMED, run_switch raised before next rise -> one tick per rise thereafter, no duplicate at first rise; with macro undefined, button press in HALT -> no tick.
- reset_n pulsed low while ARMED and mid-tick -> tick drops same cycle, tick_count=0, running=0, next rise produces no tick.

Source files
------------

// File: rtl/clock_enable_gen.sv
// clock_enable_gen
// Turns the prescaler's divided clock into one-cycle enable pulses in the
// clock_in domain. The TD4 core therefore runs on clock_in with an enable
// rather than on a derived clock. Also provides run/halt control and an
// optional debounced single-step button.
//
// Optional feature: define CLOCK_ENABLE_GEN_MANUAL_STEP_EN to build the
// step-button synchronizer, the debouncer and the ARMED state. Without it,
// step_button is ignored and HALT can only leave to RUN.
`timescale 1ns/1ps

module clock_enable_gen #(
  parameter int SYNC_STAGES     = 2,        // depth of each input synchronizer, >= 2
  parameter int DEBOUNCE_CYCLES = 1000000,  // stable cycles before a button level is accepted, >= 2
  parameter int COUNT_WIDTH     = 8         // width of tick_count
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   slow_clock,
  input  logic                   run_switch,
  input  logic                   step_button,
  output logic                   tick,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] tick_count
);

  // FSM encoding
  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  logic [SYNC_STAGES-1:0] slow_sync;
  logic [SYNC_STAGES-1:0] run_sync;
  logic                   slow_s;
  logic                   run_s;
  logic                   slow_prev;
  logic                   rise;
  logic [1:0]             state;
  logic [1:0]             state_next;
  logic                   tick_next;

  assign slow_s = slow_sync[SYNC_STAGES-1];
  assign run_s  = run_sync[SYNC_STAGES-1];

  // Shift slow_clock and run_switch through their synchronizer chains
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      slow_sync <= '0;
      run_sync  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage capture its
      // pre-edge neighbour; blocking ones would collapse the chain.
      slow_sync <= {slow_sync[SYNC_STAGES-2:0], slow_clock};
      run_sync  <= {run_sync[SYNC_STAGES-2:0], run_switch};
    end
  end

  // Detect the synchronized slow_clock rising edge. The pulse is held in a
  // flop so the FSM decision and the tick register both see a clean,
  // glitch-free one-cycle rise, placing tick on the (SYNC_STAGES+1)th edge.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      slow_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      slow_prev <= slow_s;
      rise      <= slow_s & ~slow_prev;
    end
  end

`ifdef CLOCK_ENABLE_GEN_MANUAL_STEP_EN
  // Counter just wide enough to reach DEBOUNCE_CYCLES-1
  localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   btn_s;
  logic                   db_level;
  logic [DB_W-1:0]        db_count;
  logic                   press;

  assign btn_s = btn_sync[SYNC_STAGES-1];

  // Synchronize the raw step button
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], step_button};
    end
  end

  // Debounce: accept a new level only after it differs from the current
  // one for DEBOUNCE_CYCLES consecutive cycles; pulse press on 0->1 only.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      db_count <= '0;
      db_level <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == db_level) begin
        db_count <= '0;
      end else if (db_count == DB_MAX) begin
        db_count <= '0;
        db_level <= btn_s;
        press    <= btn_s;
      end else begin
        db_count <= db_count + DB_W'(1);
      end
    end
  end
`else
  // Button is not used in this build; the port stays for pin compatibility.
  logic unused_step_button;
  assign unused_step_button = step_button;
`endif

  // Next-state logic for HALT / RUN / ARMED
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch
    // is inferred.
    state_next = state;
    case (state)
      ST_HALT: begin
        if (run_s) begin
          state_next = ST_RUN;
        end
`ifdef CLOCK_ENABLE_GEN_MANUAL_STEP_EN
        else if (press) begin
          state_next = ST_ARMED;
        end
`endif
      end
      ST_RUN: begin
        if (!run_s) begin
          state_next = ST_HALT;
        end
      end
      ST_ARMED: begin
        // A raised run switch absorbs the pending step; otherwise the
        // step fires on the next rise and returns to HALT.
        if (run_s) begin
          state_next = ST_RUN;
        end else if (rise) begin
          state_next = ST_HALT;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  // A tick is issued on rise when the current state allows it; the decision
  // uses the current state, so a same-cycle switch change still ticks.
  assign tick_next = rise & ((state == ST_RUN) | (state == ST_ARMED));

  // State and registered outputs
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_HALT;
      tick       <= 1'b0;
      running    <= 1'b0;
      tick_count <= '0;
    end else begin
      state      <= state_next;
      tick       <= tick_next;
      running    <= (state == ST_RUN);
      tick_count <= tick_count + COUNT_WIDTH'(tick_next);
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// COUNT_WIDTH=4 and a 20-cycle slow_clock. slow_clock goes high when the
// bench phase counter becomes 0; the resulting tick is expected in the
// cycle where phase reads 4 (sampling edge +3).
`timescale 1ns/1ps

module tb_clock_enable_gen;

  localparam int CW = 4;
`ifdef CLOCK_ENABLE_GEN_MANUAL_STEP_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic          clock_in    = 1'b0;
  logic          reset_n     = 1'b0;
  logic          slow_clock  = 1'b0;
  logic          run_switch  = 1'b0;
  logic          step_button = 1'b0;
  logic          tick;
  logic          running;
  logic [CW-1:0] tick_count;

  int            vectors     = 0;
  int            miscompares = 0;
  int            phase       = 19;
  bit            slow_en     = 1'b0;
  logic [CW-1:0] exp_cnt     = '0;

  clock_enable_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .slow_clock (slow_clock),
    .run_switch (run_switch),
    .step_button(step_button),
    .tick       (tick),
    .running    (running),
    .tick_count (tick_count)
  );

  always #5 clock_in = ~clock_in;

  // Advance one clock: drive slow_clock just after the edge, return on the
  // falling edge where outputs are sampled and other inputs are driven.
  task automatic next_cycle();
    @(posedge clock_in);
    #1;
    if (slow_en) begin
      phase      = (phase == 19) ? 0 : phase + 1;
      slow_clock = (phase < 10);
    end
    @(negedge clock_in);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    slow_en     = 1'b0;
    slow_clock  = 1'b0;
    phase       = 19;
    run_switch  = 1'b0;
    step_button = 1'b0;
    exp_cnt     = '0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    run_switch  = 1'b1;
    slow_clock  = 1'b1;
    step_button = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0 || running !== 1'b0 || tick_count !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d: tick=%b running=%b count=%0d want 0/0/0", i, tick, running, tick_count);
      end
    end
    run_switch  = 1'b0;
    slow_clock  = 1'b0;
    step_button = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0 || running !== 1'b0 || tick_count !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d: tick=%b running=%b count=%0d want 0/0/0", i, tick, running, tick_count);
      end
    end
  endtask

  task automatic test_run();
    int   ticks = 0;
    logic exp_b;
    run_switch = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c >= 3) begin
        exp_b = (c >= 4);
        vectors++;
        if (running !== exp_b) begin
          miscompares++;
          $display("FAIL run_latency cyc=%0d: running=%b want %b", c, running, exp_b);
        end
      end
    end
    slow_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      exp_b = (phase == 4);
      vectors++;
      if (tick !== exp_b) begin
        miscompares++;
        $display("FAIL run_tick cyc=%0d phase=%0d: tick=%b want %b", i, phase, tick, exp_b);
      end
      if (tick === 1'b1) ticks++;
    end
    vectors++;
    if (ticks != 5) begin
      miscompares++;
      $display("FAIL run_tick_total: saw %0d ticks want 5", ticks);
    end
    vectors++;
    if (tick_count !== 4'd5 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL run_end: count=%0d running=%b want 5/1", tick_count, running);
    end
  endtask

  task automatic test_wrap();
    logic exp_b;
    do_reset();
    run_switch = 1'b1;
    for (int i = 0; i < 6; i++) next_cycle();
    slow_en = 1'b1;
    for (int i = 0; i < 340; i++) begin
      next_cycle();
      exp_b = (phase == 4);
      if (exp_b) exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (tick !== exp_b || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL wrap cyc=%0d: tick=%b count=%0d want %b/%0d", i, tick, tick_count, exp_b, exp_cnt);
      end
    end
    vectors++;
    if (tick_count !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_final: count=%0d want 1", tick_count);
    end
  endtask

  // run_switch drops so that the synchronized 0 coincides with the rise
  task automatic test_run_drop();
    logic exp_b;
    logic exp_r;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_pre cyc=%0d: tick=%b want 0", i, tick);
      end
    end
    run_switch = 1'b0;
    for (int i = 0; i < 38; i++) begin
      next_cycle();
      exp_b = (i == 2);
      exp_r = (i <= 2);
      if (exp_b) exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (tick !== exp_b || running !== exp_r || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL run_drop cyc=%0d: tick=%b running=%b count=%0d want %b/%b/%0d",
                 i, tick, running, tick_count, exp_b, exp_r, exp_cnt);
      end
    end
  endtask

  task automatic test_const_slow();
    logic exp_b;
    slow_en    = 1'b0;
    run_switch = 1'b1;
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0 || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL const_low cyc=%0d: tick=%b count=%0d want 0/%0d", i, tick, tick_count, exp_cnt);
      end
    end
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL const_running: running=%b want 1", running);
    end
    slow_clock = 1'b1;
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      exp_b = (i == 3);
      if (exp_b) exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (tick !== exp_b || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL const_high cyc=%0d: tick=%b count=%0d want %b/%0d", i, tick, tick_count, exp_b, exp_cnt);
      end
    end
    slow_clock = 1'b0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++;
        $display("FAIL const_fall cyc=%0d: tick=%b want 0", i, tick);
      end
    end
    run_switch = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();
    vectors++;
    if (running !== 1'b0 || tick_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL const_halt: running=%b count=%0d want 0/%0d", running, tick_count, exp_cnt);
    end
  endtask

  // Button held 10 cycles in HALT, starting at phase 6
  task automatic test_step();
    logic exp_b;
    do_reset();
    slow_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++;
        $display("FAIL step_pre cyc=%0d: tick=%b want 0", i, tick);
      end
    end
    step_button = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      exp_b = STEP && (i == 17);
      if (exp_b) exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (tick !== exp_b || running !== 1'b0 || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL step cyc=%0d: tick=%b running=%b count=%0d want %b/0/%0d",
                 i, tick, running, tick_count, exp_b, exp_cnt);
      end
      if (i == 9) step_button = 1'b0;
    end
  endtask

  // Bouncing button never stable for 4 cycles: no press, no tick
  task automatic test_glitch();
    logic [0:11] pat = 12'b1110_1110_1100;
    step_button = pat[0];
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0 || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL glitch cyc=%0d: tick=%b count=%0d want 0/%0d", i, tick, tick_count, exp_cnt);
      end
      step_button = (i + 1 < 12) ? pat[i+1] : 1'b0;
    end
  endtask

  // Press, then raise run_switch so it is seen in the same cycle as the rise
  task automatic test_armed_run();
    logic exp_b;
    logic exp_r;
    step_button = 1'b1;
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      exp_b = (STEP && i == 17) || (i == 37) || (i == 57);
      exp_r = (i >= 18);
      if (exp_b) exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (tick !== exp_b || running !== exp_r || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL armed_run cyc=%0d: tick=%b running=%b count=%0d want %b/%b/%0d",
                 i, tick, running, tick_count, exp_b, exp_r, exp_cnt);
      end
      if (i == 9)  step_button = 1'b0;
      if (i == 14) run_switch  = 1'b1;
    end
  endtask

  // Reset asserted while tick is high: everything clears at once
  task automatic test_reset_mid_tick();
    logic exp_b;
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      exp_b = (i == 17);
      if (exp_b) exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (tick !== exp_b || tick_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL midtick_pre cyc=%0d: tick=%b count=%0d want %b/%0d", i, tick, tick_count, exp_b, exp_cnt);
      end
    end
    reset_n    = 1'b0;
    run_switch = 1'b0;
    exp_cnt    = '0;
    #1;
    vectors++;
    if (tick !== 1'b0 || tick_count !== 4'd0 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL midtick_async: tick=%b count=%0d running=%b want 0/0/0", tick, tick_count, running);
    end
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0 || tick_count !== 4'd0 || running !== 1'b0) begin
        miscompares++;
        $display("FAIL midtick_after cyc=%0d: tick=%b count=%0d running=%b want 0/0/0",
                 i, tick, tick_count, running);
      end
    end
  endtask

  // Reset while a step is pending: the step is discarded
  task automatic test_reset_armed();
    step_button = 1'b1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      vectors++;
      if (tick !== 1'b0 || tick_count !== 4'd0 || running !== 1'b0) begin
        miscompares++;
        $display("FAIL armed_reset cyc=%0d: tick=%b count=%0d running=%b want 0/0/0",
                 i, tick, tick_count, running);
      end
      if (i == 8) begin
        reset_n     = 1'b0;
        step_button = 1'b0;
        #1;
        vectors++;
        if (tick !== 1'b0 || running !== 1'b0) begin
          miscompares++;
          $display("FAIL armed_reset_async: tick=%b running=%b want 0/0", tick, running);
        end
      end
      if (i == 10) reset_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_run_drop();
    test_const_slow();
    test_step();
    test_glitch();
    test_armed_run();
    test_reset_mid_tick();
    test_reset_armed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
